// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch request path.
// Holds the fetch FSM state enum, reset PC default and bus size code.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h1c000000;
  localparam logic [1:0]  SIZE_WORD    = 2'b10;

  function automatic logic [31:0] pc_inc(
    input logic [31:0] pc
  );
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_redirect_buf.sv
// Redirect priority select plus pending-redirect register.
// Ports: ex/br redirect inputs, clr, redir_now/redir_pc, pr_valid/pr_pc.
module fetch_redirect_buf
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_en,
  input  logic [31:0] ex_entry,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        clr,
  output logic        redir_now,
  output logic [31:0] redir_pc,
  output logic        pr_valid,
  output logic [31:0] pr_pc
);

  logic        pr_valid_d;
  logic        pr_valid_q;
  logic [31:0] pr_pc_d;
  logic [31:0] pr_pc_q;

  always_comb begin
    redir_now  = ex_en | br_taken;
    redir_pc   = ex_en ? ex_entry : br_target;
    pr_valid_d = pr_valid_q;
    pr_pc_d    = pr_pc_q;
    // clr wins: a same-cycle redirect is consumed
    // by the request being entered.
    if (clr) begin
      pr_valid_d = 1'b0;
    end else if (redir_now) begin
      pr_valid_d = 1'b1;
      pr_pc_d    = redir_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pr_valid_q <= 1'b0;
      pr_pc_q    <= 32'd0;
    end else begin
      pr_valid_q <= pr_valid_d;
      pr_pc_q    <= pr_pc_d;
    end
  end

  assign pr_valid = pr_valid_q;
  assign pr_pc    = pr_pc_q;

endmodule

// File: rtl/fetch_req_ctrl.sv
// One-outstanding instruction fetch controller on an SRAM-like bus.
// Ports: redirects in, inst_sram_* bus, fs_* word offered to IF.
module fetch_req_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_en,
  input  logic [31:0] ex_entry,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        if_allowin,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  output logic        fs_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst
);

  fetch_state_e state_d;
  fetch_state_e state_q;
  logic         req_d;
  logic         req_q;
  logic         discard_d;
  logic         discard_q;
  logic [31:0]  req_pc_d;
  logic [31:0]  req_pc_q;
  logic [31:0]  pc_buf_d;
  logic [31:0]  pc_buf_q;
  logic [31:0]  inst_buf_d;
  logic [31:0]  inst_buf_q;

  logic         enter_req;
  logic [31:0]  next_pc;
  logic         redir_now;
  logic [31:0]  redir_pc;
  logic         pr_valid;
  logic [31:0]  pr_pc;

  fetch_redirect_buf u_redir (
    .clk       (clk),
    .resetn    (resetn),
    .ex_en     (ex_en),
    .ex_entry  (ex_entry),
    .br_taken  (br_taken),
    .br_target (br_target),
    .clr       (enter_req),
    .redir_now (redir_now),
    .redir_pc  (redir_pc),
    .pr_valid  (pr_valid),
    .pr_pc     (pr_pc)
  );

  // req_pc resets to RESET_PC-4 so the
  // sequential path out of IDLE lands on RESET_PC.
  always_comb begin
    if (redir_now) begin
      next_pc = redir_pc;
    end else if (pr_valid) begin
      next_pc = pr_pc;
    end else begin
      next_pc = pc_inc(req_pc_q);
    end
  end

  always_comb begin
    state_d    = state_q;
    req_pc_d   = req_pc_q;
    discard_d  = discard_q;
    pc_buf_d   = pc_buf_q;
    inst_buf_d = inst_buf_q;
    enter_req  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        enter_req = 1'b1;
      end
      S_REQ: begin
        if (inst_sram_addr_ok) begin
          state_d   = S_WAIT;
          discard_d = pr_valid | redir_now;
        end
      end
      S_WAIT: begin
        if (inst_sram_data_ok) begin
          if (discard_q | redir_now) begin
            discard_d = 1'b0;
            enter_req = 1'b1;
          end else begin
            state_d    = S_HOLD;
            pc_buf_d   = req_pc_q;
            inst_buf_d = inst_sram_rdata;
          end
        end else if (redir_now) begin
          discard_d = 1'b1;
        end
      end
      S_HOLD: begin
        // A redirect suppresses the handoff and
        // drops the buffered word.
        if (redir_now | if_allowin) begin
          enter_req = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (enter_req) begin
      state_d  = S_REQ;
      req_pc_d = next_pc;
    end
    req_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      discard_q  <= 1'b0;
      req_pc_q   <= RESET_PC - 32'd4;
      pc_buf_q   <= RESET_PC - 32'd4;
      inst_buf_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      discard_q  <= discard_d;
      req_pc_q   <= req_pc_d;
      pc_buf_q   <= pc_buf_d;
      inst_buf_q <= inst_buf_d;
    end
  end

  assign inst_sram_req  = req_q;
  assign inst_sram_wr   = 1'b0;
  assign inst_sram_size = SIZE_WORD;
  assign inst_sram_addr = req_pc_q;
  assign fs_valid       = (state_q == S_HOLD) & ~redir_now;
  assign fs_pc          = pc_buf_q;
  assign fs_inst        = inst_buf_q;

endmodule

// File: tb/tb_fetch_req_ctrl.sv
// Self-checking bench for fetch_req_ctrl.
// Transaction-level model plus directed and random stimulus.
module tb_fetch_req_ctrl;

  localparam logic [31:0] RPC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_en;
  logic [31:0] ex_entry;
  logic        br_taken;
  logic [31:0] br_target;
  logic        if_allowin;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        fs_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;

  always #5 clk = ~clk;

  fetch_req_ctrl dut (
    .clk               (clk),
    .resetn            (resetn),
    .ex_en             (ex_en),
    .ex_entry          (ex_entry),
    .br_taken          (br_taken),
    .br_target         (br_target),
    .if_allowin        (if_allowin),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (addr_ok),
    .inst_sram_data_ok (data_ok),
    .inst_sram_rdata   (rdata),
    .fs_valid          (fs_valid),
    .fs_pc             (fs_pc),
    .fs_inst           (fs_inst)
  );

  int vectors = 0;
  int errors  = 0;
  int aok_pct = 100;
  int dok_pct = 100;

  // model: transaction view of the fetch path
  bit          m_idle;
  bit          m_req;
  bit          m_infl;
  bit          m_buf;
  bit          m_pend;
  logic [31:0] m_addr;
  logic [31:0] m_last;
  logic [31:0] m_pend_pc;
  logic [31:0] m_bpc;
  logic [31:0] m_binst;
  logic [31:0] bus_addr;

  logic        s_req;
  logic        s_fsv;
  logic [31:0] s_addr;
  logic [31:0] s_pc;
  logic [31:0] s_inst;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9e3779b1) ^ 32'h0f0f5a5a;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idle = 1'b1;
    m_req  = 1'b0;
    m_infl = 1'b0;
    m_buf  = 1'b0;
    m_pend = 1'b0;
    m_last = RPC - 32'd4;
    m_addr = 32'd0;
  endtask

  // Called at posedge+1 with redirect/allowin/reset already set.
  task automatic step();
    logic        redir;
    logic [31:0] tgt;
    logic [31:0] nxt;
    bit          new_req;
    addr_ok = m_req && ($urandom_range(99) < aok_pct);
    data_ok = m_infl && ($urandom_range(99) < dok_pct);
    rdata   = data_ok ? mem(bus_addr) : $urandom();
    #2;
    s_req  = inst_sram_req;
    s_addr = inst_sram_addr;
    s_fsv  = fs_valid;
    s_pc   = fs_pc;
    s_inst = fs_inst;
    redir = ex_en | br_taken;
    tgt   = ex_en ? ex_entry : br_target;
    chk("req", {31'd0, s_req}, {31'd0, m_req});
    if (m_req) chk("addr", s_addr, m_addr);
    chk("wr", {31'd0, inst_sram_wr}, 32'd0);
    chk("size", {30'd0, inst_sram_size}, 32'd2);
    chk("fs_valid", {31'd0, s_fsv}, {31'd0, m_buf && !redir});
    if (m_buf && !redir) begin
      chk("fs_pc", s_pc, m_bpc);
      chk("fs_inst", s_inst, m_binst);
    end
    // advance model across the coming edge
    nxt = redir ? tgt : (m_pend ? m_pend_pc : m_last + 32'd4);
    new_req = 1'b0;
    if (!resetn) begin
      model_reset();
    end else begin
      if (m_idle) begin
        m_idle  = 1'b0;
        new_req = 1'b1;
      end else if (m_req) begin
        if (addr_ok) begin
          m_req    = 1'b0;
          m_infl   = 1'b1;
          bus_addr = m_addr;
        end
      end else if (m_infl) begin
        if (data_ok) begin
          m_infl = 1'b0;
          // stale iff any redirect is outstanding
          if (m_pend || redir) begin
            new_req = 1'b1;
          end else begin
            m_buf   = 1'b1;
            m_bpc   = m_last;
            m_binst = rdata;
          end
        end
      end else if (m_buf) begin
        if (redir || if_allowin) begin
          m_buf   = 1'b0;
          new_req = 1'b1;
        end
      end
      if (new_req) begin
        m_req  = 1'b1;
        m_addr = nxt;
        m_last = nxt;
        m_pend = 1'b0;
      end else if (redir) begin
        m_pend    = 1'b1;
        m_pend_pc = tgt;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ex_en = 1'b0;
    br_taken = 1'b0;
    if_allowin = 1'b1;
    aok_pct = 100;
    dok_pct = 100;
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    ex_en = 1'b0;
    br_taken = 1'b0;
    ex_entry = 32'd0;
    br_target = 32'd0;
    if_allowin = 1'b1;
    addr_ok = 1'b0;
    data_ok = 1'b0;
    rdata = 32'd0;
    model_reset();
    @(posedge clk);
    #1;

    // zero-wait streaming from reset
    do_reset();
    chk("rst_fs_pc", s_pc, 32'h1bfffffc);
    chk("rst_fs_inst", s_inst, 32'd0);
    chk("rst_req", {31'd0, s_req}, 32'd0);
    step();
    chk("t1_idle_req", {31'd0, s_req}, 32'd0);
    step();
    chk("t1_a0", s_addr, 32'h1c000000);
    step();
    step();
    chk("t1_v0", {31'd0, s_fsv}, 32'd1);
    chk("t1_i0", s_inst, mem(32'h1c000000));
    step();
    chk("t1_a1", s_addr, 32'h1c000004);
    step();
    step();
    chk("t1_v1", {31'd0, s_fsv}, 32'd1);
    chk("t1_p1", s_pc, 32'h1c000004);
    step();
    chk("t1_a2", s_addr, 32'h1c000008);

    // branch while REQ is stalled
    do_reset();
    repeat (4) step();
    aok_pct = 0;
    br_taken = 1'b1;
    br_target = 32'h1c000100;
    step();
    chk("t2_addr0", s_addr, 32'h1c000004);
    br_taken = 1'b0;
    step();
    chk("t2_addr1", s_addr, 32'h1c000004);
    aok_pct = 100;
    step();
    chk("t2_addr2", s_addr, 32'h1c000004);
    step();
    chk("t2_drop", {31'd0, s_fsv}, 32'd0);
    step();
    chk("t2_redir", s_addr, 32'h1c000100);
    chk("t2_req", {31'd0, s_req}, 32'd1);

    // ex and br together during WAIT
    do_reset();
    step();
    step();
    dok_pct = 0;
    ex_en = 1'b1;
    ex_entry = 32'h1c008000;
    br_taken = 1'b1;
    br_target = 32'h1c000200;
    step();
    ex_en = 1'b0;
    br_taken = 1'b0;
    dok_pct = 100;
    step();
    chk("t3_drop", {31'd0, s_fsv}, 32'd0);
    step();
    chk("t3_addr", s_addr, 32'h1c008000);

    // HOLD with IF stalled
    do_reset();
    if_allowin = 1'b0;
    repeat (3) step();
    repeat (4) begin
      step();
      chk("t4_v", {31'd0, s_fsv}, 32'd1);
      chk("t4_pc", s_pc, 32'h1c000000);
      chk("t4_inst", s_inst, mem(32'h1c000000));
      chk("t4_noreq", {31'd0, s_req}, 32'd0);
    end
    if_allowin = 1'b1;
    step();
    step();
    chk("t4_next", s_addr, 32'h1c000004);

    // redirect coincident with handoff
    do_reset();
    repeat (3) step();
    br_taken = 1'b1;
    br_target = 32'h1c000300;
    step();
    chk("t5_supp", {31'd0, s_fsv}, 32'd0);
    br_taken = 1'b0;
    step();
    chk("t5_addr", s_addr, 32'h1c000300);

    // reset during WAIT
    do_reset();
    step();
    step();
    dok_pct = 0;
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    dok_pct = 100;
    step();
    chk("t6_req", {31'd0, s_req}, 32'd0);
    chk("t6_fsv", {31'd0, s_fsv}, 32'd0);
    step();
    chk("t6_addr", s_addr, 32'h1c000000);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      resetn = ($urandom_range(199) != 0);
      ex_en = ($urandom_range(99) < 4);
      br_taken = ($urandom_range(99) < 8);
      ex_entry = $urandom() & 32'hfffffffc;
      br_target = ($urandom_range(9) == 0) ? 32'hfffffffc
                                            : ($urandom() & 32'hfffffffc);
      if_allowin = ($urandom_range(99) < 70);
      aok_pct = $urandom_range(30, 100);
      dok_pct = $urandom_range(30, 100);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
